// File: rtl/axi_master_response_control.sv
// AXI master response side: B/R one-entry stages into the response FIFOs, plus R burst tracking.
// Optional sticky error logging is enabled by defining AXI_RESP_ERR_LOG_EN.
module axi_master_response_control #(
  parameter int DW              = 32,
  parameter int BEAT_SIZE       = 32*DW,
  parameter int ID_WIDTH        = 10,
  parameter int RESP_WIDTH      = 2,
  parameter int B_CHANNEL_WIDTH = ID_WIDTH+RESP_WIDTH,
  parameter int R_CHANNEL_WIDTH = ID_WIDTH+RESP_WIDTH+1+BEAT_SIZE
) (
  input  logic                       i_clk,
  input  logic                       i_n_rst,
  input  logic [ID_WIDTH-1:0]        i_s_BID,
  input  logic [RESP_WIDTH-1:0]      i_s_BRESP,
  input  logic                       i_s_BVALID,
  output logic                       o_s_BREADY,
  output logic [B_CHANNEL_WIDTH-1:0] o_B_CHANNEL_fifo,
  output logic                       o_b_fifo_write_inc,
  input  logic                       i_b_fifo_full,
  input  logic [ID_WIDTH-1:0]        i_s_RID,
  input  logic [BEAT_SIZE-1:0]       i_s_RDATA,
  input  logic [RESP_WIDTH-1:0]      i_s_RRESP,
  input  logic                       i_s_RLAST,
  input  logic                       i_s_RVALID,
  output logic                       o_s_RREADY,
  output logic [R_CHANNEL_WIDTH-1:0] o_R_CHANNEL_fifo,
  output logic                       o_r_fifo_write_inc,
  input  logic                       i_r_fifo_full,
  output logic                       o_r_burst_done,
  output logic [8:0]                 o_r_burst_beats,
  output logic [RESP_WIDTH-1:0]      o_r_burst_resp,
  input  logic                       i_err_clr,
  output logic [2:0]                 o_err_status
);

  typedef enum logic {R_IDLE = 1'b0, R_BURST = 1'b1} r_state_e;
  localparam logic [8:0] MAX_BEATS = 9'd256;

  logic                       r_b_vld, r_r_vld, r_r_tag;
  logic [B_CHANNEL_WIDTH-1:0] r_b_data;
  logic [R_CHANNEL_WIDTH-1:0] r_r_data;
  logic [8:0]                 r_tag_beats, r_last_beats, r_cnt;
  logic [RESP_WIDTH-1:0]      r_tag_resp, r_last_resp, r_acc;
  r_state_e                   r_state, w_state_nx;
  logic                       w_b_hs, w_r_hs, w_done, w_arm, w_ovf;
  logic [8:0]                 w_cnt_nx, w_cnt_inc, w_arm_beats;
  logic [RESP_WIDTH-1:0]      w_acc_nx, w_arm_resp, w_rmax;

  // B stage
  assign o_s_BREADY         = ~r_b_vld | ~i_b_fifo_full;
  assign o_b_fifo_write_inc = r_b_vld & ~i_b_fifo_full;
  assign o_B_CHANNEL_fifo   = r_b_data;
  assign w_b_hs             = i_s_BVALID & o_s_BREADY;

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_b_vld  <= 1'b0;
      r_b_data <= '0;
    end else if (w_b_hs) begin
      r_b_vld  <= 1'b1;
      r_b_data <= {i_s_BID, i_s_BRESP};
    end else if (o_b_fifo_write_inc) begin
      r_b_vld  <= 1'b0;
    end
  end

  // R stage; the done tag travels with the beat it was armed on
  assign o_s_RREADY         = ~r_r_vld | ~i_r_fifo_full;
  assign o_r_fifo_write_inc = r_r_vld & ~i_r_fifo_full;
  assign o_R_CHANNEL_fifo   = r_r_data;
  assign w_r_hs             = i_s_RVALID & o_s_RREADY;
  assign w_done             = o_r_fifo_write_inc & r_r_tag;
  assign o_r_burst_done     = w_done;
  assign o_r_burst_beats    = w_done ? r_tag_beats : r_last_beats;
  assign o_r_burst_resp     = w_done ? r_tag_resp  : r_last_resp;

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_r_vld      <= 1'b0;
      r_r_data     <= '0;
      r_r_tag      <= 1'b0;
      r_tag_beats  <= '0;
      r_tag_resp   <= '0;
      r_last_beats <= '0;
      r_last_resp  <= '0;
    end else begin
      if (w_r_hs) begin
        r_r_vld     <= 1'b1;
        r_r_data    <= {i_s_RID, i_s_RRESP, i_s_RLAST, i_s_RDATA};
        r_r_tag     <= w_arm;
        r_tag_beats <= w_arm_beats;
        r_tag_resp  <= w_arm_resp;
      end else if (o_r_fifo_write_inc) begin
        r_r_vld     <= 1'b0;
        r_r_tag     <= 1'b0;
      end
      if (w_done) begin
        r_last_beats <= r_tag_beats;
        r_last_resp  <= r_tag_resp;
      end
    end
  end

  // Burst FSM: state register
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_acc   <= w_acc_nx;
    end
  end

  assign w_cnt_inc = (r_cnt >= MAX_BEATS) ? MAX_BEATS : r_cnt + 9'd1;
  assign w_rmax    = (i_s_RRESP > r_acc) ? i_s_RRESP : r_acc;

  // Burst FSM: next state
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_acc_nx   = r_acc;
    if (w_r_hs) begin
      case (r_state)
        R_IDLE: if (!i_s_RLAST) begin
          w_state_nx = R_BURST;
          w_cnt_nx   = 9'd1;
          w_acc_nx   = i_s_RRESP;
        end
        R_BURST: if (i_s_RLAST || r_cnt == MAX_BEATS) begin
          w_state_nx = R_IDLE;
          w_cnt_nx   = '0;
          w_acc_nx   = '0;
        end else begin
          w_cnt_nx   = w_cnt_inc;
          w_acc_nx   = w_rmax;
        end
        default: w_state_nx = R_IDLE;
      endcase
    end
  end

  // Burst FSM: outputs (done arming and overflow)
  always_comb begin
    w_arm       = 1'b0;
    w_arm_beats = '0;
    w_arm_resp  = '0;
    w_ovf       = 1'b0;
    if (w_r_hs) begin
      if (r_state == R_IDLE) begin
        if (i_s_RLAST) begin
          w_arm       = 1'b1;
          w_arm_beats = 9'd1;
          w_arm_resp  = i_s_RRESP;
        end
      end else if (i_s_RLAST) begin
        w_arm       = 1'b1;
        w_arm_beats = w_cnt_inc;
        w_arm_resp  = w_rmax;
      end else if (r_cnt == MAX_BEATS) begin
        // overrun beat is forwarded but not counted in the closed burst
        w_arm       = 1'b1;
        w_arm_beats = MAX_BEATS;
        w_arm_resp  = r_acc;
        w_ovf       = 1'b1;
      end
    end
  end

`ifdef AXI_RESP_ERR_LOG_EN
  logic [2:0] r_err, w_err_set;
  assign w_err_set = {w_ovf,
                      w_r_hs & (i_s_RRESP >= 2'd2),
                      w_b_hs & (i_s_BRESP >= 2'd2)};
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) r_err <= '0;
    else          r_err <= (r_err & {3{~i_err_clr}}) | w_err_set;
  end
  assign o_err_status = r_err;
`else
  logic w_unused_err;
  assign w_unused_err = i_err_clr | w_ovf;
  assign o_err_status = '0;
`endif

endmodule

// File: tb/tb_axi_master_response_control.sv
// Directed bench for axi_master_response_control: reset, B path, R bursts, stall, overflow, reset mid-burst.
module tb_axi_master_response_control;
  localparam int BS = 1024;
  localparam int RW = 10+2+1+BS;
`ifdef AXI_RESP_ERR_LOG_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic i_clk = 0, i_n_rst = 0;
  logic [9:0] i_s_BID = 0, i_s_RID = 0;
  logic [1:0] i_s_BRESP = 0, i_s_RRESP = 0;
  logic i_s_BVALID = 0, i_b_fifo_full = 0, i_s_RLAST = 0, i_s_RVALID = 0, i_r_fifo_full = 0, i_err_clr = 0;
  logic [BS-1:0] i_s_RDATA = '0;
  logic o_s_BREADY, o_b_fifo_write_inc, o_s_RREADY, o_r_fifo_write_inc, o_r_burst_done;
  logic [11:0] o_B_CHANNEL_fifo;
  logic [RW-1:0] o_R_CHANNEL_fifo;
  logic [8:0] o_r_burst_beats;
  logic [1:0] o_r_burst_resp;
  logic [2:0] o_err_status;

  axi_master_response_control dut (
    .i_clk(i_clk), .i_n_rst(i_n_rst),
    .i_s_BID(i_s_BID), .i_s_BRESP(i_s_BRESP), .i_s_BVALID(i_s_BVALID), .o_s_BREADY(o_s_BREADY),
    .o_B_CHANNEL_fifo(o_B_CHANNEL_fifo), .o_b_fifo_write_inc(o_b_fifo_write_inc), .i_b_fifo_full(i_b_fifo_full),
    .i_s_RID(i_s_RID), .i_s_RDATA(i_s_RDATA), .i_s_RRESP(i_s_RRESP), .i_s_RLAST(i_s_RLAST),
    .i_s_RVALID(i_s_RVALID), .o_s_RREADY(o_s_RREADY),
    .o_R_CHANNEL_fifo(o_R_CHANNEL_fifo), .o_r_fifo_write_inc(o_r_fifo_write_inc), .i_r_fifo_full(i_r_fifo_full),
    .o_r_burst_done(o_r_burst_done), .o_r_burst_beats(o_r_burst_beats), .o_r_burst_resp(o_r_burst_resp),
    .i_err_clr(i_err_clr), .o_err_status(o_err_status));

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic [31:0] wq[$];
  int          wc[$], dc[$];
  logic [8:0]  db[$];
  logic [1:0]  dr[$];
  logic [11:0] bq[$];

  always @(negedge i_clk) begin
    if (o_r_fifo_write_inc) begin
      wq.push_back(o_R_CHANNEL_fifo[31:0]);
      wc.push_back(cyc);
    end
    if (o_r_burst_done) begin
      db.push_back(o_r_burst_beats);
      dr.push_back(o_r_burst_resp);
      dc.push_back(cyc);
    end
    if (o_b_fifo_write_inc) bq.push_back(o_B_CHANNEL_fifo);
  end

  int n_chk = 0, n_fail = 0, hs0 = 0, stalls = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wq.delete(); wc.delete(); dc.delete(); db.delete(); dr.delete(); bq.delete();
  endtask

  task automatic drain();
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  // master that honours RREADY; fifo full asserted for cycles [ff, ff+fl) of the run
  task automatic send_r(input int n, input bit last_en, input int ff, input int fl,
                        input logic [31:0] pat, input logic [31:0] base);
    int idx = 0, c = 0;
    bit hs = 0, full;
    while (1) begin
      @(posedge i_clk); #1;
      if (hs) idx++;
      hs = 0;
      full = (c >= ff) && (c < ff + fl);
      i_r_fifo_full = full;
      if (idx >= n) begin
        i_s_RVALID = 0; i_s_RLAST = 0; i_r_fifo_full = 0;
        break;
      end
      i_s_RVALID = 1; i_s_RID = 10'h2A;
      i_s_RDATA = '0; i_s_RDATA[31:0] = base + idx;
      i_s_RRESP = (idx < 16) ? pat[2*idx +: 2] : 2'b00;
      i_s_RLAST = last_en && (idx == n - 1);
      #3;
      hs = o_s_RREADY;
      if (hs && idx == 0) hs0 = cyc;
      if (full) chk("rready_full", o_s_RREADY, 0);
      c++;
      if (c > n + 50) begin
        chk("send_r_timeout", 1, 0);
        i_s_RVALID = 0; i_r_fifo_full = 0;
        break;
      end
    end
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_bready"}, o_s_BREADY, 1);
    chk({p, "_rready"}, o_s_RREADY, 1);
    chk({p, "_bwr"}, o_b_fifo_write_inc, 0);
    chk({p, "_rwr"}, o_r_fifo_write_inc, 0);
    chk({p, "_done"}, o_r_burst_done, 0);
    chk({p, "_beats"}, o_r_burst_beats, 0);
    chk({p, "_resp"}, o_r_burst_resp, 0);
    chk({p, "_err"}, o_err_status, 0);
    chk({p, "_bbus"}, o_B_CHANNEL_fifo, 0);
    chk({p, "_rbus0"}, (o_R_CHANNEL_fifo == '0), 1);
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1 chk_reset_vals("rst");
    i_n_rst = 1;

    // single B
    @(posedge i_clk); #1;
    i_s_BVALID = 1; i_s_BID = 10'h155; i_s_BRESP = 2'b00;
    #3 chk("b_ready", o_s_BREADY, 1);
    chk("b_wr_early", o_b_fifo_write_inc, 0);
    @(posedge i_clk); #1 i_s_BVALID = 0;
    #3 chk("b_wr", o_b_fifo_write_inc, 1);
    chk("b_data", o_B_CHANNEL_fifo, 12'h554);
    @(posedge i_clk); #4 chk("b_wr_once", o_b_fifo_write_inc, 0);

    // 4-beat burst, RRESP 00,00,10,00
    clear_logs();
    send_r(4, 1, 0, 0, 32'h0000_0020, 32'h100);
    drain();
    chk("r4_writes", wq.size(), 4);
    for (int i = 0; i < 4; i++) chk("r4_data", wq[i], 32'h100 + i);
    chk("r4_latency", wc[0] - hs0, 1);
    chk("r4_span", wc[3] - wc[0], 3);
    chk("r4_done_n", dc.size(), 1);
    chk("r4_beats", db[0], 4);
    chk("r4_resp", dr[0], 2);
    chk("r4_done_cyc", dc[0], wc[3]);
    chk("r4_hold_beats", o_r_burst_beats, 4);
    chk("r4_hold_resp", o_r_burst_resp, 2);
    chk("r4_err", o_err_status, EN ? 3'b010 : 3'b000);
    i_err_clr = 1;
    @(posedge i_clk); #1 i_err_clr = 0;
    #3 chk("err_clr", o_err_status, 0);

    // 8-beat burst with 3-cycle fifo full mid-burst
    clear_logs();
    send_r(8, 1, 3, 3, 32'h0, 32'h200);
    drain();
    chk("st_writes", wq.size(), 8);
    for (int i = 0; i < 8; i++) chk("st_data", wq[i], 32'h200 + i);
    chk("st_done_n", dc.size(), 1);
    chk("st_beats", db[0], 8);

    // 257 beats without RLAST
    clear_logs();
    send_r(257, 0, 0, 0, 32'h0, 32'h1000);
    drain();
    chk("ov_writes", wq.size(), 257);
    chk("ov_last_data", wq[256], 32'h1100);
    chk("ov_done_n", dc.size(), 1);
    chk("ov_beats", db[0], 256);
    chk("ov_done_cyc", dc[0], wc[256]);
    chk("ov_err", o_err_status, EN ? 3'b100 : 3'b000);
    clear_logs();
    send_r(1, 1, 0, 0, 32'h0, 32'h2000);
    drain();
    chk("ov_next_done_n", dc.size(), 1);
    chk("ov_next_beats", db[0], 1);

    // reset after beat 2 of a 4-beat burst
    clear_logs();
    send_r(2, 0, 0, 0, 32'h0, 32'h300);
    @(posedge i_clk); #1 i_n_rst = 0;
    #3 chk_reset_vals("mid");
    @(posedge i_clk); #1 i_n_rst = 1;
    chk("mid_no_done", dc.size(), 0);
    send_r(1, 1, 0, 0, 32'h0, 32'h400);
    drain();
    chk("mid_next_done_n", dc.size(), 1);
    chk("mid_next_beats", db[0], 1);

    // simultaneous B and R every cycle for 16 cycles
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      @(posedge i_clk); #1;
      i_s_BVALID = 1; i_s_BID = 10'(i); i_s_BRESP = 2'b01;
      i_s_RVALID = 1; i_s_RDATA = '0; i_s_RDATA[31:0] = 32'h500 + i; i_s_RRESP = 0;
      i_s_RLAST = (i == 15);
      #3 if (!o_s_BREADY || !o_s_RREADY) stalls++;
    end
    @(posedge i_clk); #1 i_s_BVALID = 0; i_s_RVALID = 0; i_s_RLAST = 0;
    drain();
    chk("sim_stalls", stalls, 0);
    chk("sim_bwrites", bq.size(), 16);
    chk("sim_b15", bq[15], {10'd15, 2'b01});
    chk("sim_rwrites", wq.size(), 16);
    chk("sim_r15", wq[15], 32'h50F);
    chk("sim_beats", db[0], 16);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end
endmodule
